wb_gpio: RTL and testbench



---
 rtl/wb_gpio_pkg.sv | 34 +++
 rtl/wb_gpio_if.sv | 28 ++
 rtl/wb_gpio_sync.sv | 47 ++++
 rtl/wb_gpio.sv | 142 ++++++++++++++
 tb/tb_wb_gpio.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_gpio_pkg.sv
// wb_gpio shared definitions: register offsets, register index
// enum, pin limit and the Wishbone byte-enable mask helper.
package wb_gpio_pkg;

  localparam int MAX_PINS = 32;

  localparam logic [4:0] REG_DATA_IN    = 5'h00;
  localparam logic [4:0] REG_DATA_OUT   = 5'h04;
  localparam logic [4:0] REG_DIR        = 5'h08;
  localparam logic [4:0] REG_SET        = 5'h0C;
  localparam logic [4:0] REG_CLR        = 5'h10;
  localparam logic [4:0] REG_IRQ_EN     = 5'h14;
  localparam logic [4:0] REG_IRQ_TYPE   = 5'h18;
  localparam logic [4:0] REG_IRQ_STATUS = 5'h1C;

  typedef enum logic [2:0] {
    IDX_DATA_IN    = REG_DATA_IN[4:2],
    IDX_DATA_OUT   = REG_DATA_OUT[4:2],
    IDX_DIR        = REG_DIR[4:2],
    IDX_SET        = REG_SET[4:2],
    IDX_CLR        = REG_CLR[4:2],
    IDX_IRQ_EN     = REG_IRQ_EN[4:2],
    IDX_IRQ_TYPE   = REG_IRQ_TYPE[4:2],
    IDX_IRQ_STATUS = REG_IRQ_STATUS[4:2]
  } reg_idx_e;

  function automatic logic [31:0] sel_mask(
    input logic [3:0] sel
  );
    return {{8{sel[3]}}, {8{sel[2]}},
            {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_gpio_if.sv
// Wishbone classic bus bundle: adr, dat_w, dat_r, cyc, stb,
// we, sel, ack, err, with master and slave modports.
interface wb_if
  import wb_gpio_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, cyc, stb, we, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, cyc, stb, we, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_gpio_sync.sv
// Pad input synchroniser (i_d -> o_q) with rising/falling
// edge pulses (o_rise/o_fall); edges only with WB_GPIO_IRQ_EN.
module wb_gpio_sync
  import wb_gpio_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++)
        r_sync[k] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int k = 1; k < STAGES; k++)
        r_sync[k] <= r_sync[k-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

`ifdef WB_GPIO_IRQ_EN
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_prev <= '0;
    else       r_prev <= o_q;
  end

  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
`else
  assign o_rise = '0;
  assign o_fall = '0;
`endif

endmodule

// File: rtl/wb_gpio.sv
// Wishbone GPIO: clk, rstn, s (wb slave), gpio_i/o/oe, int_o.
// Edge interrupts only when WB_GPIO_IRQ_EN is defined.
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int NUM_PINS      = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                rstn,
  wb_if.slave                 s,
  input  logic [NUM_PINS-1:0] gpio_i,
  output logic [NUM_PINS-1:0] gpio_o,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                int_o
);

  logic                     r_ack;
  logic [MAX_PINS-1:0]      r_dat;
  logic [NUM_PINS-1:0]      r_dout;
  logic [NUM_PINS-1:0]      r_dir;
  logic [NUM_PINS-1:0]      w_din;
  logic [NUM_PINS-1:0]      w_rise;
  logic [NUM_PINS-1:0]      w_fall;
  logic [WB_DATA_WIDTH-1:0] w_bm;
  logic [NUM_PINS-1:0]      w_bmp;
  logic [NUM_PINS-1:0]      w_wd;
  logic [MAX_PINS-1:0]      w_rdata;
  logic                     w_acc;
  logic                     w_wr;
  reg_idx_e                 w_idx;
  logic                     w_unused;

  wb_gpio_sync #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .i_d    (gpio_i),
    .o_q    (w_din),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Accept only when ack is low: one ack per two cycles if held.
  assign w_acc = s.cyc & s.stb & ~r_ack;
  assign w_wr  = w_acc & s.we;
  assign w_idx = reg_idx_e'(s.adr[4:2]);
  assign w_bm  = sel_mask(s.sel);
  assign w_bmp = w_bm[NUM_PINS-1:0];
  assign w_wd  = s.dat_w[NUM_PINS-1:0] & w_bmp;

`ifdef WB_GPIO_IRQ_EN
  logic [NUM_PINS-1:0] r_ien;
  logic [NUM_PINS-1:0] r_ityp;
  logic [NUM_PINS-1:0] r_ists;
  logic [NUM_PINS-1:0] w_hit;
  logic [NUM_PINS-1:0] w_w1c;
  logic                r_int;

  assign w_hit = r_ien & ((r_ityp & w_rise) |
                          (~r_ityp & w_fall));
  assign w_w1c = (w_wr && w_idx == IDX_IRQ_STATUS) ?
                 w_wd : '0;

  // Set is OR-ed in after the clear so a new edge wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ien  <= '0;
      r_ityp <= '0;
      r_ists <= '0;
      r_int  <= 1'b0;
    end else begin
      r_ists <= (r_ists & ~w_w1c) | w_hit;
      r_int  <= |r_ists;
      if (w_wr) begin
        unique case (w_idx)
          IDX_IRQ_EN:
            r_ien <= (r_ien & ~w_bmp) | w_wd;
          IDX_IRQ_TYPE:
            r_ityp <= (r_ityp & ~w_bmp) | w_wd;
          default: ;
        endcase
      end
    end
  end

  assign int_o    = r_int;
  assign w_unused = ^{s.adr[WB_ADDR_WIDTH-1:5],
                      s.adr[1:0]};
`else
  assign int_o    = 1'b0;
  assign w_unused = ^{s.adr[WB_ADDR_WIDTH-1:5],
                      s.adr[1:0], w_rise, w_fall};
`endif

  always_comb begin
    w_rdata = '0;
    unique case (w_idx)
      IDX_DATA_IN:    w_rdata[NUM_PINS-1:0] = w_din;
      IDX_DATA_OUT:   w_rdata[NUM_PINS-1:0] = r_dout;
      IDX_DIR:        w_rdata[NUM_PINS-1:0] = r_dir;
`ifdef WB_GPIO_IRQ_EN
      IDX_IRQ_EN:     w_rdata[NUM_PINS-1:0] = r_ien;
      IDX_IRQ_TYPE:   w_rdata[NUM_PINS-1:0] = r_ityp;
      IDX_IRQ_STATUS: w_rdata[NUM_PINS-1:0] = r_ists;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_dout <= '0;
      r_dir  <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_acc ? w_rdata : '0;
      if (w_wr) begin
        unique case (w_idx)
          IDX_DATA_OUT: r_dout <= (r_dout & ~w_bmp) | w_wd;
          IDX_DIR:      r_dir  <= (r_dir & ~w_bmp) | w_wd;
          IDX_SET:      r_dout <= r_dout | w_wd;
          IDX_CLR:      r_dout <= r_dout & ~w_wd;
          default: ;
        endcase
      end
    end
  end

  assign s.dat_r = r_dat;
  assign s.ack   = r_ack;
  assign s.err   = 1'b0;
  assign gpio_o  = r_dout;
  assign gpio_oe = r_dir;

endmodule

// File: tb/tb_wb_gpio.sv
// Bench for wb_gpio: 32-pin DUT against a per-cycle model,
// plus an 8-pin DUT for the pin-width boundary.
module tb_wb_gpio;
  localparam int SYNC = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_if #(.AW(32), .DW(32)) b32 ();
  wb_if #(.AW(32), .DW(32)) b8 ();

  logic [31:0] gpio_i;
  logic [31:0] gpio_o;
  logic [31:0] gpio_oe;
  logic        int_o;
  logic [7:0]  g8_o;
  logic [7:0]  g8_oe;
  logic        int8;

  wb_gpio #(
    .NUM_PINS(32), .SYNC_STAGES(SYNC)
  ) u_dut (
    .clk(clk), .rstn(rstn), .s(b32.slave),
    .gpio_i(gpio_i), .gpio_o(gpio_o),
    .gpio_oe(gpio_oe), .int_o(int_o)
  );

  wb_gpio #(
    .NUM_PINS(8), .SYNC_STAGES(SYNC)
  ) u_d8 (
    .clk(clk), .rstn(rstn), .s(b8.slave),
    .gpio_i(gpio_i[7:0]), .gpio_o(g8_o),
    .gpio_oe(g8_oe), .int_o(int8)
  );

  int n_pass = 0;
  int n_tot  = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h",
                  nm, act, exp);
  endtask

  // Model: register contents plus a history of sampled pad
  // values; the synchronised view lags the pads by SYNC edges.
  logic [31:0] m_dout, m_dir, m_en, m_typ, m_sts, m_rd;
  logic        m_ack, m_int;
  logic [31:0] hist [0:SYNC];

  always @(posedge clk or negedge rstn) begin : model
    logic [31:0] msk, wd, hit, clr, rv, last, prev;
    if (!rstn) begin
      m_dout = 0; m_dir = 0; m_en = 0; m_typ = 0;
      m_sts = 0; m_rd = 0; m_ack = 0; m_int = 0;
      for (int k = 0; k <= SYNC; k++) hist[k] = 0;
    end else begin
      last = hist[SYNC-1];
      prev = hist[SYNC];
      hit = 0;
      for (int n = 0; n < 32; n++)
        if (m_en[n] && last[n] != prev[n] &&
            last[n] == m_typ[n])
          hit[n] = 1'b1;
      clr = 0;
      if (b32.cyc && b32.stb && !m_ack) begin
        case (b32.adr[4:2])
          3'd0: rv = last;
          3'd1: rv = m_dout;
          3'd2: rv = m_dir;
`ifdef WB_GPIO_IRQ_EN
          3'd5: rv = m_en;
          3'd6: rv = m_typ;
          3'd7: rv = m_sts;
`endif
          default: rv = 0;
        endcase
        m_rd = rv;
        msk = {{8{b32.sel[3]}}, {8{b32.sel[2]}},
               {8{b32.sel[1]}}, {8{b32.sel[0]}}};
        wd = b32.dat_w & msk;
        if (b32.we) begin
          case (b32.adr[4:2])
            3'd1: m_dout = (m_dout & ~msk) | wd;
            3'd2: m_dir  = (m_dir & ~msk) | wd;
            3'd3: m_dout = m_dout | wd;
            3'd4: m_dout = m_dout & ~wd;
`ifdef WB_GPIO_IRQ_EN
            3'd5: m_en  = (m_en & ~msk) | wd;
            3'd6: m_typ = (m_typ & ~msk) | wd;
            3'd7: clr = wd;
`endif
            default: ;
          endcase
        end
        m_ack = 1'b1;
      end else begin
        m_ack = 1'b0;
        m_rd  = 0;
      end
      m_int = (m_sts != 0);
      m_sts = (m_sts & ~clr) | hit;
      for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = gpio_i;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_gpio_o", gpio_o, m_dout);
      chk("cyc_gpio_oe", gpio_oe, m_dir);
      chk("cyc_int_o", {31'b0, int_o}, {31'b0, m_int});
      chk("cyc_ack", {31'b0, b32.ack}, {31'b0, m_ack});
      if (b32.ack) chk("cyc_dat_r", b32.dat_r, m_rd);
    end
  end

  task automatic xfer(input bit d8, input bit we,
                      input logic [31:0] adr,
                      input logic [31:0] dat,
                      input logic [3:0] sel,
                      output logic [31:0] rdat);
    bit got = 1'b0;
    @(negedge clk);
    if (d8) begin
      b8.adr = adr; b8.dat_w = dat; b8.sel = sel;
      b8.we = we; b8.cyc = 1'b1; b8.stb = 1'b1;
    end else begin
      b32.adr = adr; b32.dat_w = dat; b32.sel = sel;
      b32.we = we; b32.cyc = 1'b1; b32.stb = 1'b1;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = d8 ? b8.ack : b32.ack;
    end
    rdat = d8 ? b8.dat_r : b32.dat_r;
    if (d8) begin
      b8.cyc = 1'b0; b8.stb = 1'b0; b8.we = 1'b0;
    end else begin
      b32.cyc = 1'b0; b32.stb = 1'b0; b32.we = 1'b0;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] sel = 4'hF);
    logic [31:0] x;
    xfer(1'b0, 1'b1, a, d, sel, x);
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] exp,
                    input string nm);
    logic [31:0] x;
    xfer(1'b0, 1'b0, a, 32'd0, 4'hF, x);
    chk(nm, x, exp);
  endtask

  task automatic wr8(input logic [31:0] a,
                     input logic [31:0] d);
    logic [31:0] x;
    xfer(1'b1, 1'b1, a, d, 4'hF, x);
  endtask

  task automatic rd8(input logic [31:0] a,
                     input logic [31:0] exp,
                     input string nm);
    logic [31:0] x;
    xfer(1'b1, 1'b0, a, 32'd0, 4'hF, x);
    chk(nm, x, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int acks;
    b32.adr = 0; b32.dat_w = 0; b32.sel = 0;
    b32.we = 0; b32.cyc = 0; b32.stb = 0;
    b8.adr = 0; b8.dat_w = 0; b8.sel = 0;
    b8.we = 0; b8.cyc = 0; b8.stb = 0;
    gpio_i = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    cmp_en = 1'b1;

    for (int a = 0; a < 8; a++)
      rd(a * 4, 32'h0, "rst_read");
    chk("rst_gpio_o", gpio_o, 32'h0);
    chk("rst_gpio_oe", gpio_oe, 32'h0);
    chk("rst_int_o", {31'b0, int_o}, 32'h0);

    wr(32'h08, 32'h0000_00FF);
    wr(32'h04, 32'h0000_00A5);
    wr(32'h0C, 32'h0000_0102);
    wr(32'h10, 32'h0000_0001);
    chk("setclr_gpio_o", gpio_o, 32'h0000_01A6);
    rd(32'h04, 32'h0000_01A6, "setclr_rd");
    chk("dir_gpio_oe", gpio_oe, 32'h0000_00FF);

    wr(32'h04, 32'h0);
    wr(32'h04, 32'hFFFF_FFFF, 4'b0010);
    rd(32'h04, 32'h0000_FF00, "sel_dout");
    rd(32'h8000_0FE4, 32'h0000_FF00, "alias");
    wr(32'h0C, 32'hFFFF_FFFF, 4'b0001);
    rd(32'h04, 32'h0000_FFFF, "sel_set");
    wr(32'h10, 32'hFFFF_FFFF, 4'b0010);
    rd(32'h04, 32'h0000_00FF, "sel_clr");

    gpio_i = 32'h1234_5678;
    repeat (SYNC + 1) @(negedge clk);
    rd(32'h00, 32'h1234_5678, "din");
    wr(32'h00, 32'hDEAD_BEEF);
    rd(32'h00, 32'h1234_5678, "din_ro");
    gpio_i = 32'hCAFE_0000;
    rd(32'h00, 32'h1234_5678, "din_lat_old");
    rd(32'h00, 32'hCAFE_0000, "din_lat_new");

    @(negedge clk);
    b32.adr = 32'h04; b32.we = 1'b0;
    b32.cyc = 1'b1; b32.stb = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      acks += int'(b32.ack);
    end
    b32.cyc = 1'b0; b32.stb = 1'b0;
    chk("held_acks", acks, 32'd2);

`ifdef WB_GPIO_IRQ_EN
    gpio_i = 32'h0000_0008;
    repeat (SYNC + 3) @(negedge clk);
    wr(32'h14, 32'h1);
    wr(32'h18, 32'h1);
    @(negedge clk);
    gpio_i = 32'h0000_0009;
    for (int k = 1; k <= SYNC + 2; k++) begin
      @(negedge clk);
      if (k == SYNC + 1)
        chk("irq_int_early", {31'b0, int_o}, 32'h0);
      if (k == SYNC + 2)
        chk("irq_int_high", {31'b0, int_o}, 32'h1);
    end
    rd(32'h1C, 32'h1, "irq_sts");
    wr(32'h1C, 32'h1);
    chk("w1c_int_hold", {31'b0, int_o}, 32'h1);
    @(negedge clk);
    chk("w1c_int_low", {31'b0, int_o}, 32'h0);
    rd(32'h1C, 32'h0, "w1c_sts");

    gpio_i = 32'h0000_000B;
    repeat (SYNC + 3) @(negedge clk);
    rd(32'h1C, 32'h0, "irq_masked");

    wr(32'h14, 32'h9);
    @(negedge clk);
    gpio_i = 32'h0000_0003;
    repeat (SYNC - 1) @(negedge clk);
    wr(32'h1C, 32'h8);
    rd(32'h1C, 32'h8, "set_wins");
    chk("set_wins_int", {31'b0, int_o}, 32'h1);
    wr(32'h14, 32'h0);
    rd(32'h1C, 32'h8, "en_clr_keeps");
    wr(32'h1C, 32'hFFFF_FFFF, 4'b0010);
    rd(32'h1C, 32'h8, "w1c_sel");
    wr(32'h1C, 32'h8);
    rd(32'h1C, 32'h0, "w1c_bit3");
    rd(32'h18, 32'h1, "irq_type_rd");
`else
    wr(32'h14, 32'hFFFF_FFFF);
    wr(32'h18, 32'hFFFF_FFFF);
    wr(32'h1C, 32'hFFFF_FFFF);
    rd(32'h14, 32'h0, "noirq_en");
    rd(32'h18, 32'h0, "noirq_type");
    rd(32'h1C, 32'h0, "noirq_sts");
    for (int i = 0; i < 6; i++) begin
      gpio_i = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
      repeat (SYNC + 2) @(negedge clk);
      chk("noirq_int", {31'b0, int_o}, 32'h0);
    end
    gpio_i = 32'h0000_0003;
    repeat (SYNC + 1) @(negedge clk);
`endif

    wr8(32'h04, 32'hFFFF_FFFF);
    rd8(32'h04, 32'h0000_00FF, "p8_dout");
    chk("p8_gpio_o", {24'b0, g8_o}, 32'h0000_00FF);
    wr8(32'h08, 32'hFFFF_FFFF);
    rd8(32'h08, 32'h0000_00FF, "p8_dir");
    chk("p8_gpio_oe", {24'b0, g8_oe}, 32'h0000_00FF);
    rd8(32'h00, 32'h0000_0003, "p8_din");

    wr(32'h04, 32'h0000_00F0);
    @(negedge clk);
    b32.adr = 32'h04; b32.dat_w = 32'h0000_0055;
    b32.sel = 4'hF; b32.we = 1'b1;
    b32.cyc = 1'b1; b32.stb = 1'b1;
    #1 rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_ack", {31'b0, b32.ack}, 32'h0);
    chk("rst_mid_gpio_o", gpio_o, 32'h0);
    b32.cyc = 1'b0; b32.stb = 1'b0; b32.we = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    rd(32'h04, 32'h0, "rst_mid_dout");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
